// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter/serialiser between the IF and MEM pipeline stages and a
// single byte-wide unified RAM port.
//
// Each granted access is split into little-endian byte transfers. Loads are
// reassembled, sign/zero extended, and finished with a one-cycle enable pulse
// to the requester that owns the transaction. MEM requests win over IF.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes the controller
//   jump_or_not     pipeline flush; kills IF-owned transactions
//   if_*            IF stage: word fetch request / result / completion pulse
//   mem_*           MEM stage: 1/2/4-byte load/store request / result / pulse
//   ram_*           byte RAM port (read data is valid one cycle after address)
//
// Optional build macro
//   IO_BUF_STALL_EN adds io_buffer_full; stores into the IO region
//                   (addr[17:16] == 2'b11) wait while it is high.

module mem_ctrl #(
  parameter int AddrLen = 32,
  parameter int InstLen = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_or_not,
  input  logic               if_request,
  input  logic [AddrLen-1:0] if_addr,
  output logic [InstLen-1:0] if_inst_o,
  output logic               if_enable,
  input  logic               mem_request,
  input  logic               mem_we,
  input  logic [AddrLen-1:0] mem_addr,
  input  logic [2:0]         mem_len,
  input  logic               mem_signed,
  input  logic [InstLen-1:0] mem_data_i,
  output logic [InstLen-1:0] mem_data_o,
  output logic               mem_enable,
`ifdef IO_BUF_STALL_EN
  input  logic               io_buffer_full,
`endif
  input  logic [7:0]         ram_din,
  output logic [7:0]         ram_dout,
  output logic [AddrLen-1:0] ram_a,
  output logic               ram_wr
);

  typedef enum logic [1:0] {IDLE, BUSY, TAIL, DONE} state_t;

  state_t             state, state_n;
  logic [1:0]         cnt;       // index of the byte currently on the bus
  logic [1:0]         len_m1;    // transfer length minus one
  logic [AddrLen-1:0] base;
  logic [InstLen-1:0] wdata;
  logic               we_q;
  logic               own_if;
  logic               sgn_q;
  logic               wr_q;
  logic [InstLen-1:0] buf_q;     // read assembly buffer
  logic [InstLen-1:0] rd_next;
  logic [1:0]         prev_idx;  // byte index presented on the bus last cycle
  logic               prev_vld;  // ... and whether it was a read byte
  logic               grant_mem, grant_if, step, flush, io_hold;
  logic [1:0]         cnt_inc;
  logic [1:0]         len_dec;

`ifdef IO_BUF_STALL_EN
  logic io_q;
  assign io_hold = io_q & io_buffer_full;
`else
  assign io_hold = 1'b0;
`endif

  assign flush   = own_if & jump_or_not;
  assign cnt_inc = cnt + 2'd1;
  assign len_dec = (mem_len == 3'd1) ? 2'd0 : (mem_len == 3'd2) ? 2'd1 : 2'd3;

  // Next state and per-edge control
  always_comb begin
    state_n   = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_request) begin
          grant_mem = 1'b1;
          state_n   = BUSY;
        end else if (if_request && !jump_or_not) begin
          grant_if = 1'b1;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        if (flush) state_n = IDLE;
        else if (!io_hold) begin
          if (cnt == len_m1) state_n = we_q ? DONE : TAIL;
          else               step    = 1'b1;
        end
      end
      TAIL:    state_n = flush ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_n;
  end

  // Read data arriving now belongs to the address presented last cycle, so the
  // sampler tracks the bus every cycle (rdy included). This keeps the byte
  // alignment right across freezes, when the held address is simply re-read.
  always_comb begin
    rd_next = buf_q;
    if (prev_vld) rd_next[8*prev_idx +: 8] = ram_din;
  end

  function automatic logic [InstLen-1:0] extend(input logic [InstLen-1:0] r,
                                                input logic [1:0] lm1,
                                                input logic sg);
    case (lm1)
      2'd0:    extend = {{(InstLen-8){sg & r[7]}}, r[7:0]};
      2'd1:    extend = {{(InstLen-16){sg & r[15]}}, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      len_m1     <= '0;
      base       <= '0;
      wdata      <= '0;
      we_q       <= 1'b0;
      own_if     <= 1'b0;
      sgn_q      <= 1'b0;
      wr_q       <= 1'b0;
      buf_q      <= '0;
      prev_idx   <= '0;
      prev_vld   <= 1'b0;
      ram_a      <= '0;
      ram_dout   <= '0;
      if_inst_o  <= '0;
      mem_data_o <= '0;
`ifdef IO_BUF_STALL_EN
      io_q       <= 1'b0;
`endif
    end else begin
      prev_vld <= (state == BUSY) && !we_q;
      prev_idx <= cnt;
      if (prev_vld) buf_q <= rd_next;
      if (rdy) begin
        if (grant_mem || grant_if) begin
          cnt      <= '0;
          base     <= grant_mem ? mem_addr : if_addr;
          ram_a    <= grant_mem ? mem_addr : if_addr;
          len_m1   <= grant_mem ? len_dec : 2'd3;
          we_q     <= grant_mem & mem_we;
          wr_q     <= grant_mem & mem_we;
          own_if   <= grant_if;
          sgn_q    <= mem_signed;
          wdata    <= mem_data_i;
          ram_dout <= grant_mem ? mem_data_i[7:0] : 8'h00;
`ifdef IO_BUF_STALL_EN
          io_q     <= grant_mem & mem_we & (mem_addr[17:16] == 2'b11);
`endif
        end else begin
          if (step) begin
            cnt      <= cnt_inc;
            ram_a    <= base + AddrLen'(cnt_inc);
            ram_dout <= wdata[8*cnt_inc +: 8];
          end
          if (state_n != BUSY) wr_q <= 1'b0;
          if (state == TAIL && state_n == DONE) begin
            if (own_if) if_inst_o  <= rd_next;
            else        mem_data_o <= extend(rd_next, len_m1, sgn_q);
          end
        end
      end
    end
  end

  // A stalled IO byte or a frozen cycle must not strobe the RAM
  assign ram_wr     = wr_q & rdy & ~io_hold;
  assign if_enable  = (state == DONE) & own_if & ~jump_or_not & rdy;
  assign mem_enable = (state == DONE) & ~own_if & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model (read data registered
// one cycle behind the address). Expected values are hand-computed.

module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, jump_or_not;
  logic        if_request;
  logic [31:0] if_addr;
  logic [31:0] if_inst_o;
  logic        if_enable;
  logic        mem_request, mem_we, mem_signed;
  logic [31:0] mem_addr, mem_data_i, mem_data_o;
  logic [2:0]  mem_len;
  logic        mem_enable;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
`ifdef IO_BUF_STALL_EN
  logic        io_buffer_full = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  logic [7:0] ram [0:1023];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_or_not(jump_or_not),
    .if_request(if_request), .if_addr(if_addr), .if_inst_o(if_inst_o),
    .if_enable(if_enable),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_signed(mem_signed), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_enable(mem_enable),
`ifdef IO_BUF_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    rst = 1'b1; rdy = 1'b1; jump_or_not = 1'b0;
    if_request = 1'b0; if_addr = '0;
    mem_request = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = 3'd4;
    mem_signed = 1'b0; mem_data_i = '0;
    tick(); tick();
    chk("rst_ra",   ram_a, 32'h0);
    chk("rst_wr",   32'(ram_wr), 32'h0);
    chk("rst_ifen", 32'(if_enable), 32'h0);
    chk("rst_men",  32'(mem_enable), 32'h0);
    rst = 1'b0;
    tick();

    // 1: IF word read at 0x100
    ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h00;
    if_addr = 32'h100; if_request = 1'b1;
    tick();
    if_request = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) chk("t1_ra", ram_a, 32'h100 + 32'(k));
      chk("t1_wr", 32'(ram_wr), 32'h0);
      chk("t1_en", 32'(if_enable), 32'(k == 5));
      if (k == 5) chk("t1_inst", if_inst_o, 32'h0000_0513);
      tick();
    end

    // 2: simultaneous MEM load and IF fetch, MEM first
    ram[10'h200] <= 8'h11; ram[10'h201] <= 8'h22; ram[10'h202] <= 8'h33; ram[10'h203] <= 8'h44;
    ram[10'h000] <= 8'h93; ram[10'h001] <= 8'h00; ram[10'h002] <= 8'h10; ram[10'h003] <= 8'h00;
    mem_request = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h200;
    if_request = 1'b1; if_addr = 32'h0;
    tick();
    mem_request = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) chk("t2_ra_mem", ram_a, 32'h200);
      if (k == 7) begin
        chk("t2_ra_if", ram_a, 32'h0);
        if_request = 1'b0;
      end
      chk("t2_men", 32'(mem_enable), 32'(k == 5));
      chk("t2_ifen", 32'(if_enable), 32'(k == 12));
      if (k == 5)  chk("t2_mdata", mem_data_o, 32'h4433_2211);
      if (k == 12) chk("t2_inst", if_inst_o, 32'h0010_0093);
      tick();
    end

    // 3: byte load of 0x80, signed then unsigned
    ram[10'h010] <= 8'h80;
    for (int s = 0; s < 2; s++) begin
      mem_request = 1'b1; mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h10;
      mem_signed = (s == 0);
      tick();
      mem_request = 1'b0;
      tick(); tick();
      chk("t3_men", 32'(mem_enable), 32'h1);
      chk("t3_data", mem_data_o, (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
      chk("t3_men_clr", 32'(mem_enable), 32'h0);
    end
    mem_signed = 1'b0;

    // 4: half store of 0xBEEF at 0x20
    mem_request = 1'b1; mem_we = 1'b1; mem_len = 3'd2; mem_addr = 32'h20;
    mem_data_i = 32'h1234_BEEF;
    tick();
    mem_request = 1'b0;
    chk("t4_ra0", ram_a, 32'h20);
    chk("t4_do0", 32'(ram_dout), 32'hEF);
    chk("t4_wr0", 32'(ram_wr), 32'h1);
    tick();
    chk("t4_ra1", ram_a, 32'h21);
    chk("t4_do1", 32'(ram_dout), 32'hBE);
    chk("t4_wr1", 32'(ram_wr), 32'h1);
    tick();
    chk("t4_men", 32'(mem_enable), 32'h1);
    chk("t4_wr2", 32'(ram_wr), 32'h0);
    tick();
    mem_we = 1'b0;
    chk("t4_m20", 32'(ram[10'h020]), 32'hEF);
    chk("t4_m21", 32'(ram[10'h021]), 32'hBE);
    chk("t4_m22", 32'(ram[10'h022]), 32'h00);

    // 5: IF read flushed in cycle 2, then a clean fetch at 0x80
    ram[10'h080] <= 8'h37; ram[10'h081] <= 8'h12; ram[10'h082] <= 8'h00; ram[10'h083] <= 8'h00;
    if_addr = 32'h40; if_request = 1'b1;
    tick();
    if_request = 1'b0;
    chk("t5_en0", 32'(if_enable), 32'h0);
    tick();
    tick();
    jump_or_not = 1'b1;
    chk("t5_en2", 32'(if_enable), 32'h0);
    tick();
    jump_or_not = 1'b0;
    chk("t5_en3", 32'(if_enable), 32'h0);
    if_addr = 32'h80; if_request = 1'b1;
    tick();
    if_request = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) chk("t5_ra", ram_a, 32'h80);
      chk("t5_en", 32'(if_enable), 32'(k == 5));
      if (k == 5) chk("t5_inst", if_inst_o, 32'h0000_1237);
      tick();
    end

    // 6a: reset in cycle 1 of a word store
    mem_request = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h300;
    mem_data_i = 32'hA1B2_C3D4;
    tick();
    mem_request = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_ra",   ram_a, 32'h0);
    chk("t6_do",   32'(ram_dout), 32'h0);
    chk("t6_wr",   32'(ram_wr), 32'h0);
    chk("t6_ifen", 32'(if_enable), 32'h0);
    chk("t6_men",  32'(mem_enable), 32'h0);
    chk("t6_inst", if_inst_o, 32'h0);
    chk("t6_mdat", mem_data_o, 32'h0);
    rst = 1'b0; mem_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_nowr", 32'(ram_wr), 32'h0);
    end
    chk("t6_m300", 32'(ram[10'h300]), 32'hD4);
    chk("t6_m302", 32'(ram[10'h302]), 32'h00);
    chk("t6_m303", 32'(ram[10'h303]), 32'h00);

    // 6b: rdy low for 3 cycles in the middle of a word load
    mem_request = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h200;
    tick();
    mem_request = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) rdy = 1'b0;
      if (k == 5) rdy = 1'b1;
      if (k >= 2 && k <= 4) begin
        chk("t6b_ra", ram_a, 32'h202);
        chk("t6b_wr", 32'(ram_wr), 32'h0);
      end
      chk("t6b_men", 32'(mem_enable), 32'(k == 8));
      if (k == 8) chk("t6b_data", mem_data_o, 32'h4433_2211);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
